// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg : shared types for the APB4 memory completer
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_be_ram.sv
// ============================================================================
// apb_be_ram : DEPTH x DATA_BW storage with byte-enable write, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_be_ram #(
  parameter int DATA_BW = 32,
  parameter int DEPTH   = 64,
  parameter int IDX_BW  = 6
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [IDX_BW-1:0]    i_addr,
  input  logic [DATA_BW-1:0]   i_wdata,
  input  logic [DATA_BW/8-1:0] i_strb,
  output logic [DATA_BW-1:0]   o_rdata
);

  localparam int STRB_BW = DATA_BW / 8;

  logic [DATA_BW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_BW; b++) begin
        if (i_strb[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/apb_mem_slave.sv
// ============================================================================
// apb_mem_slave : APB4 completer over a byte-strobed word memory with
//                 wait states, pslverr and a read-only ID word
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int          DATA_BW     = 32,
  parameter int          ADDR_BW     = 8,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_BW-1:0]   paddr,
  input  logic [DATA_BW-1:0]   pwdata,
  input  logic [DATA_BW/8-1:0] pstrb,
  output logic [DATA_BW-1:0]   prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic                 err_pulse
);

  localparam int STRB_BW = DATA_BW / 8;
  localparam int OFS_BW  = $clog2(STRB_BW);
  localparam int IDX_BW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [DATA_BW-1:0] c_id_word = DATA_BW'(ID_VALUE);
  localparam logic [CNT_BW-1:0]  c_cnt_max = CNT_BW'(WAIT_CYCLES);

  apb_state_e           r_state;
  apb_state_e           w_state_nxt;
  logic [CNT_BW-1:0]    r_cnt;
  logic [CNT_BW-1:0]    w_cnt_nxt;
  logic                 w_latch;
  logic                 w_commit;

  logic [ADDR_BW-1:0]   r_addr;
  logic                 r_write;
  logic [DATA_BW-1:0]   r_wdata;
  logic [STRB_BW-1:0]   r_strb;

  logic [ADDR_BW-1:0]   w_word;
  logic                 w_misaligned;
  logic                 w_oob;
  logic                 w_is_id;
  logic                 w_err;
  logic                 w_pready;
  logic                 w_we;
  logic [DATA_BW-1:0]   w_ram_rdata;
  logic [DATA_BW-1:0]   w_rdata;

  assign w_pready = (r_state == ACCESS) && (r_cnt == c_cnt_max);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        // psel with penable already high is a protocol violation and is ignored
        if (psel && !penable) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = '0;
          w_latch     = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_pready) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_BW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_addr  <= paddr;
        r_write <= pwrite;
        r_wdata <= pwdata;
        r_strb  <= pstrb;
      end
    end
  end

  assign w_word = r_addr >> OFS_BW;

  generate
    if (OFS_BW > 0) begin : g_ofs_chk
      assign w_misaligned = |r_addr[OFS_BW-1:0];
    end else begin : g_no_ofs
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_oob   = ({1'b0, w_word} >= (ADDR_BW + 1)'(DEPTH));
  assign w_is_id = (w_word == ADDR_BW'(DEPTH - 1));
  assign w_err   = w_misaligned | w_oob | (r_write & w_is_id);
  assign w_we    = w_commit & r_write & ~w_err;

  apb_be_ram #(
    .DATA_BW (DATA_BW),
    .DEPTH   (DEPTH),
    .IDX_BW  (IDX_BW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_word[IDX_BW-1:0]),
    .i_wdata (r_wdata),
    .i_strb  (r_strb),
    .o_rdata (w_ram_rdata)
  );

  assign w_rdata   = w_is_id ? c_id_word : w_ram_rdata;
  assign pready    = w_pready;
  assign pslverr   = w_pready & w_err;
  assign err_pulse = w_pready & w_err;
  assign prdata    = (w_pready && !r_write && !w_err) ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
// ============================================================================
// tb_apb_mem_slave : randomized scoreboard bench for apb_mem_slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_mem_slave;

  localparam int          DW    = 32;
  localparam int          AW    = 9;
  localparam int          DEPTH = 64;
  localparam int          WC    = 1;
  localparam logic [31:0] IDV   = 32'hA9B0_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [DW-1:0] prdata;
  logic          pready, pslverr, err_pulse;

  apb_mem_slave #(
    .DATA_BW     (DW),
    .ADDR_BW     (AW),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WC),
    .ID_VALUE    (IDV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       mon_e;
  logic [7:0]  mb [0:DEPTH*4-1];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_prdata = '0;
  logic        last_err    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Byte-addressed reference memory; also decides the error response
  function automatic resp_t model(input bit wr, input int a, input logic [31:0] d,
                                  input logic [3:0] s);
    resp_t r;
    int    w;
    w       = a / 4;
    r.err   = (a % 4 != 0) || (w >= DEPTH) || (wr && w == DEPTH - 1);
    r.rdata = '0;
    if (!r.err && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mb[a + b] = d[8*b +: 8];
      end
    end else if (!r.err) begin
      r.rdata = (w == DEPTH - 1) ? IDV : {mb[a + 3], mb[a + 2], mb[a + 1], mb[a]};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (pready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got pready=1 expected no response");
        end else begin
          mon_e = exp_q.pop_front();
          check("prdata", prdata, mon_e.rdata);
          check("pslverr", {31'b0, pslverr}, {31'b0, mon_e.err});
          check("err_pulse", {31'b0, err_pulse}, {31'b0, mon_e.err});
          last_prdata = prdata;
          last_err    = pslverr;
        end
      end else begin
        check("idle_prdata", prdata, 32'h0);
        check("idle_pslverr", {31'b0, pslverr}, 32'h0);
        check("idle_err_pulse", {31'b0, err_pulse}, 32'h0);
      end
    end
  end

  // Entered and left at posedge+1; leaves the bus ready for an immediate setup
  task automatic xfer(input bit wr, input int a, input logic [31:0] d, input logic [3:0] s);
    int cyc;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = AW'(a);
    pwdata  = d;
    pstrb   = s;
    exp_q.push_back(model(wr, a, d, s));
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0;
    forever begin
      cyc++;
      @(negedge clk);
      if (pready) break;
      if (cyc > WC + 8) break;
      @(posedge clk); #1;
    end
    check("latency", cyc, WC + 1);
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r, a;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", {31'b0, pready}, 32'h0);
    check("rst_pslverr", {31'b0, pslverr}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_err_pulse", {31'b0, err_pulse}, 32'h0);
    rst = 1'b0;
    idle(1);

    for (int w = 0; w < DEPTH - 1; w++) xfer(1'b1, w * 4, $urandom, 4'hF);

    xfer(1'b1, 'h10, 32'hDEAD_BEEF, 4'hF);
    xfer(1'b0, 'h10, 32'h0, 4'h0);
    check("rd_deadbeef", last_prdata, 32'hDEAD_BEEF);
    xfer(1'b1, 'h10, 32'h1122_3344, 4'b0101);
    xfer(1'b0, 'h10, 32'h0, 4'h0);
    check("rd_strb_0101", last_prdata, 32'hDE22_BE44);
    xfer(1'b1, 'h10, 32'hFFFF_FFFF, 4'h0);
    xfer(1'b0, 'h10, 32'h0, 4'hF);
    check("rd_strb_none", last_prdata, 32'hDE22_BE44);

    xfer(1'b0, 'h11, 32'h0, 4'h0);
    check("err_misaligned", {31'b0, last_err}, 32'h1);
    xfer(1'b1, 'h100, 32'h1234_5678, 4'hF);
    check("err_oob", {31'b0, last_err}, 32'h1);
    xfer(1'b1, (DEPTH - 1) * 4, 32'h0, 4'hF);
    check("err_id_write", {31'b0, last_err}, 32'h1);
    xfer(1'b0, (DEPTH - 1) * 4, 32'h0, 4'h0);
    check("rd_id", last_prdata, IDV);
    check("rd_id_err", {31'b0, last_err}, 32'h0);

    for (int i = 0; i < 4; i++) xfer(1'b1, i * 4, 32'hA000_0000 + i, 4'hF);
    for (int i = 0; i < 4; i++) xfer(1'b0, i * 4, 32'h0, 4'h0);
    check("b2b_last", last_prdata, 32'hA000_0003);

    // Abort: psel dropped in the first access cycle, before pready
    if (WC > 0) begin
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'('h20);
      pwdata = 32'h5555_5555; pstrb = 4'hF;
      @(posedge clk); #1;
      psel = 1'b0;
      @(posedge clk); #1;
    end
    xfer(1'b0, 'h20, 32'h0, 4'h0);

    // Reset in the middle of a write's access phase
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'('h24);
    pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_pready", {31'b0, pready}, 32'h0);
    check("midrst_pslverr", {31'b0, pslverr}, 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    xfer(1'b0, 'h24, 32'h0, 4'h0);

    repeat (300) begin
      r = int'($urandom % 10);
      if (r < 7)       a = int'($urandom % DEPTH) * 4;
      else if (r == 7) a = int'($urandom % DEPTH) * 4 + 1 + int'($urandom % 3);
      else if (r == 8) a = 256 + int'($urandom % 256);
      else             a = (DEPTH - 1) * 4;
      xfer(1'($urandom), a, $urandom, 4'($urandom));
      idle(int'($urandom % 3));
    end

    idle(3);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
